// File: rtl/combo_lock_param.sv
`default_nettype none
// ============================================================================
// Module      : combo_lock_param
// Description : Programmable combination lock with retry limit and timed
//               lockout. The master override code is enabled by defining
//               COMBO_LOCK_OVERRIDE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module combo_lock_param #(
  parameter int unsigned       CODE_W        = 16,
  parameter int unsigned       MAX_TRIES     = 3,
  parameter int unsigned       LOCKOUT_CYC   = 1000,
  parameter logic [CODE_W-1:0] OVERRIDE_CODE = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              press,
  input  logic [CODE_W-1:0] in,
  output logic              lock,
  output logic [3:0]        state_out,
  output logic [3:0]        tries_left,
  output logic              alarm
);

  localparam int unsigned          c_CNT_W      = $clog2(LOCKOUT_CYC);
  localparam logic [c_CNT_W-1:0]   c_CNT_LAST   = c_CNT_W'(LOCKOUT_CYC - 1);
  localparam logic [c_CNT_W-1:0]   c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [3:0]           c_TRIES_INIT = 4'(MAX_TRIES);

  typedef enum logic [3:0] {
    S_SET     = 4'd0,
    S_CONFIRM = 4'd1,
    S_LOCKED  = 4'd2,
    S_OPEN    = 4'd3,
    S_LOCKOUT = 4'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_press_q;
  logic                r_armed;
  logic [CODE_W-1:0]   r_cand, w_cand_nxt;
  logic [CODE_W-1:0]   r_user, w_user_nxt;
  logic [3:0]          r_tries, w_tries_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic                w_evt;
  logic                w_ovr_hit;

`ifdef COMBO_LOCK_OVERRIDE_EN
  assign w_ovr_hit = (in == OVERRIDE_CODE);
`else
  logic w_unused_ovr;
  assign w_unused_ovr = ^OVERRIDE_CODE;
  assign w_ovr_hit    = 1'b0;
`endif

  // r_armed blocks a press that was already held when reset was released.
  assign w_evt = press & ~r_press_q & r_armed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_SET;
      r_press_q <= 1'b0;
      r_armed   <= 1'b0;
      r_cand    <= '0;
      r_user    <= '0;
      r_tries   <= c_TRIES_INIT;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_press_q <= press;
      r_armed   <= r_armed | ~press;
      r_cand    <= w_cand_nxt;
      r_user    <= w_user_nxt;
      r_tries   <= w_tries_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_user_nxt  = r_user;
    w_tries_nxt = r_tries;
    w_cnt_nxt   = '0;
    case (r_state)
      S_SET: begin
        if (w_evt && !w_ovr_hit) begin
          w_cand_nxt  = in;
          w_state_nxt = S_CONFIRM;
        end
      end
      S_CONFIRM: begin
        if (w_evt) begin
          if (in == r_cand) begin
            w_user_nxt  = in;
            w_tries_nxt = c_TRIES_INIT;
            w_state_nxt = S_LOCKED;
          end else begin
            w_state_nxt = S_SET;
          end
        end
      end
      S_LOCKED: begin
        if (w_evt) begin
          if (w_ovr_hit || (in == r_user)) begin
            w_tries_nxt = c_TRIES_INIT;
            w_state_nxt = S_OPEN;
          end else if (r_tries <= 4'd1) begin
            w_tries_nxt = 4'd0;
            w_state_nxt = S_LOCKOUT;
          end else begin
            w_tries_nxt = r_tries - 4'd1;
          end
        end
      end
      S_OPEN: begin
        if (w_evt) begin
          w_state_nxt = (in == '0) ? S_SET : S_LOCKED;
        end
      end
      S_LOCKOUT: begin
        // Non-override presses are ignored and leave the timer running.
        w_tries_nxt = 4'd0;
        if (w_evt && w_ovr_hit) begin
          w_tries_nxt = c_TRIES_INIT;
          w_state_nxt = S_OPEN;
        end else if (r_cnt == c_CNT_LAST) begin
          w_tries_nxt = c_TRIES_INIT;
          w_state_nxt = S_LOCKED;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_SET;
      end
    endcase
  end

  assign lock       = (r_state == S_LOCKED) || (r_state == S_LOCKOUT);
  assign alarm      = (r_state == S_LOCKOUT);
  assign state_out  = r_state;
  assign tries_left = r_tries;

endmodule
`default_nettype wire

// File: tb/tb_combo_lock_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_combo_lock_param
// Description : Scoreboard bench for combo_lock_param with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_combo_lock_param;

  logic        clk;
  logic        reset;
  logic        press;
  logic [15:0] in_code;
  logic        w_lock;
  logic [3:0]  w_state;
  logic [3:0]  w_tries;
  logic        w_alarm;

  combo_lock_param dut (
    .clk        (clk),
    .reset      (reset),
    .press      (press),
    .in         (in_code),
    .lock       (w_lock),
    .state_out  (w_state),
    .tries_left (w_tries),
    .alarm      (w_alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    int         cyc;
    logic [3:0] st;
    logic       lk;
    logic [3:0] tl;
    logic       al;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [3:0] st, input logic lk,
                       input logic [3:0] tl, input logic al);
    n_check++;
    if (w_state !== st || w_lock !== lk || w_tries !== tl || w_alarm !== al) begin
      n_fail++;
      $display("FAIL %s: got state=%0d lock=%0b tries=%0d alarm=%0b, want state=%0d lock=%0b tries=%0d alarm=%0b",
               nm, w_state, w_lock, w_tries, w_alarm, st, lk, tl, al);
    end
  endtask

  // Monitor: outputs settle after each rising edge; compare whatever is due.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        check(e.nm, e.st, e.lk, e.tl, e.al);
      end
    end
  end

  task automatic expect_at(input string nm, input int c, input logic [3:0] st,
                           input logic lk, input logic [3:0] tl, input logic al);
    exp_t e;
    e.nm = nm; e.cyc = c; e.st = st; e.lk = lk; e.tl = tl; e.al = al;
    sb.push_back(e);
  endtask

  // One press event; its effect is due on the next rising edge.
  task automatic ev(input string nm, input logic [15:0] v, input logic [3:0] st,
                    input logic lk, input logic [3:0] tl, input logic al);
    @(negedge clk);
    press   = 1'b1;
    in_code = v;
    expect_at(nm, cyc + 1, st, lk, tl, al);
    @(negedge clk);
    press   = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int c0;

  initial begin
    reset   = 1'b0;
    press   = 1'b0;
    in_code = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    expect_at("reset_state", cyc + 1, 4'd0, 1'b0, 4'd3, 1'b0);

    // Program 0x1234
    ev("prog_confirm", 16'h1234, 4'd1, 1'b0, 4'd3, 1'b0);
    ev("prog_locked",  16'h1234, 4'd2, 1'b1, 4'd3, 1'b0);

    // Three wrong codes, then timed lockout with an ignored user code inside
    ev("wrong1", 16'h0001, 4'd2, 1'b1, 4'd2, 1'b0);
    ev("wrong2", 16'h0002, 4'd2, 1'b1, 4'd1, 1'b0);
    ev("wrong3_lockout", 16'h0003, 4'd4, 1'b1, 4'd0, 1'b1);
    c0 = cyc;
    ev("lockout_user_ignored", 16'h1234, 4'd4, 1'b1, 4'd0, 1'b1);
    expect_at("lockout_last_cycle", c0 + 999,  4'd4, 1'b1, 4'd0, 1'b1);
    expect_at("lockout_timeout",    c0 + 1000, 4'd2, 1'b1, 4'd3, 1'b0);
    wait_until(c0 + 1001);

    // Second lockout, then the override code
    ev("wrong4", 16'h0007, 4'd2, 1'b1, 4'd2, 1'b0);
    ev("wrong5", 16'h0008, 4'd2, 1'b1, 4'd1, 1'b0);
    ev("wrong6_lockout", 16'h0009, 4'd4, 1'b1, 4'd0, 1'b1);
    c0 = cyc;
`ifdef COMBO_LOCK_OVERRIDE_EN
    ev("lockout_override_open", 16'hFFFF, 4'd3, 1'b0, 4'd3, 1'b0);
`else
    ev("lockout_ffff_ignored", 16'hFFFF, 4'd4, 1'b1, 4'd0, 1'b1);
    expect_at("lockout_timeout2", c0 + 1000, 4'd2, 1'b1, 4'd3, 1'b0);
    wait_until(c0 + 1001);
    ev("user_open", 16'h1234, 4'd3, 1'b0, 4'd3, 1'b0);
`endif

    ev("open_reprogram", 16'h0000, 4'd0, 1'b0, 4'd3, 1'b0);

`ifdef COMBO_LOCK_OVERRIDE_EN
    ev("set_override_rejected", 16'hFFFF, 4'd0, 1'b0, 4'd3, 1'b0);
`else
    ev("set_ffff_confirm", 16'hFFFF, 4'd1, 1'b0, 4'd3, 1'b0);
    ev("set_ffff_locked",  16'hFFFF, 4'd2, 1'b1, 4'd3, 1'b0);
    ev("ffff_open",        16'hFFFF, 4'd3, 1'b0, 4'd3, 1'b0);
    ev("ffff_reprogram",   16'h0000, 4'd0, 1'b0, 4'd3, 1'b0);
`endif

    ev("mismatch_confirm", 16'hBBCD, 4'd1, 1'b0, 4'd3, 1'b0);
    ev("mismatch_to_set",  16'hBBCE, 4'd0, 1'b0, 4'd3, 1'b0);

    // Held press: a second event would match the candidate and lock
    @(negedge clk);
    press   = 1'b1;
    in_code = 16'h5555;
    expect_at("held_first",  cyc + 1,  4'd1, 1'b0, 4'd3, 1'b0);
    expect_at("held_single", cyc + 20, 4'd1, 1'b0, 4'd3, 1'b0);
    repeat (21) @(negedge clk);
    press = 1'b0;
    ev("held_then_confirm", 16'h5555, 4'd2, 1'b1, 4'd3, 1'b0);

    // Full-width compare: MSB-only and LSB-only differences are wrong codes
    ev("msb_diff",  16'hD555, 4'd2, 1'b1, 4'd2, 1'b0);
    ev("lsb_diff",  16'h5554, 4'd2, 1'b1, 4'd1, 1'b0);
    ev("open_reload", 16'h5555, 4'd3, 1'b0, 4'd3, 1'b0);

    // Async reset in the middle of a lockout, press held across release
    ev("relock",  16'h0001, 4'd2, 1'b1, 4'd3, 1'b0);
    ev("wrong7",  16'h0001, 4'd2, 1'b1, 4'd2, 1'b0);
    ev("wrong8",  16'h0002, 4'd2, 1'b1, 4'd1, 1'b0);
    ev("wrong9_lockout", 16'h0003, 4'd4, 1'b1, 4'd0, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3;
    reset   = 1'b0;
    press   = 1'b1;
    in_code = 16'h2222;
    #1;
    check("async_reset", 4'd0, 1'b0, 4'd3, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    expect_at("held_through_reset", cyc + 3, 4'd0, 1'b0, 4'd3, 1'b0);
    repeat (4) @(negedge clk);
    press = 1'b0;
    ev("post_reset_confirm", 16'h2222, 4'd1, 1'b0, 4'd3, 1'b0);
    ev("post_reset_locked",  16'h2222, 4'd2, 1'b1, 4'd3, 1'b0);

    repeat (10) begin
      if (sb.size() > 0) @(negedge clk);
    end
    if (sb.size() > 0) begin
      n_check++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
